// File: rtl/aes_round_arbiter.sv
// aes_round_arbiter: shares one iterative AES round engine among NREQ requesters.
// Requesters offer 128-bit blocks over valid/ready. The arbiter grants them
// round-robin, runs the engine's start_round/done protocol and returns the
// result tagged with the requester id. An operation that never sees done
// within TIMEOUT cycles is aborted with an error response.
//
// Ports:
//   i_clk, i_rstn         clock, asynchronous active-low reset
//   i_req_valid/o_req_ready  per-requester handshake (ready is one-hot, IDLE only)
//   i_req_data            requester i block in bits [128*i +: 128]
//   o_resp_valid/i_resp_ready  result handshake
//   o_resp_id/o_resp_data/o_resp_err  result fields, held until accepted
//   o_start_round, o_aes_xin  engine start (held for whole op) and input block
//   i_aes_round_done, i_aes_xout  engine done flag and output block
//   o_busy                FSM not idle
//   o_timeout_err         sticky timeout flag, cleared only by reset
module aes_round_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [NREQ-1:0]       i_req_valid,
  input  logic [NREQ*128-1:0]   i_req_data,
  output logic [NREQ-1:0]       o_req_ready,
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  output logic [IDW-1:0]        o_resp_id,
  output logic [127:0]          o_resp_data,
  output logic                  o_resp_err,
  output logic                  o_start_round,
  output logic [127:0]          o_aes_xin,
  input  logic                  i_aes_round_done,
  input  logic [127:0]          i_aes_xout,
  output logic                  o_busy,
  output logic                  o_timeout_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StResp} state_e;

  state_e          r_state, w_state_next;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_id;
  logic [127:0]    r_block;
  logic [CntW-1:0] r_cnt;
  logic [127:0]    r_resp_data;
  logic            r_resp_err;
  logic            r_timeout_err;

  logic            w_grant_found;
  logic [IDW-1:0]  w_grant_idx;
  logic [127:0]    w_grant_data;
  logic            w_timeout_hit;

  // Round-robin search starting just after the last winner.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!w_grant_found && i_req_valid[i] && (i == (32'(r_rr_ptr) + k) % NREQ)) begin
          w_grant_found = 1'b1;
          w_grant_idx   = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    w_grant_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant_idx == IDW'(i)) w_grant_data = i_req_data[128*i +: 128];
    end
  end

  // Done takes priority over a coincident timeout.
  assign w_timeout_hit = !i_aes_round_done && (r_cnt == CntMax);

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_grant_found) w_state_next = StRun;
      StRun:   if (i_aes_round_done || w_timeout_hit) w_state_next = StResp;
      StResp:  if (i_resp_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_rr_ptr      <= IDW'(NREQ - 1);
      r_id          <= '0;
      r_block       <= '0;
      r_cnt         <= '0;
      r_resp_data   <= '0;
      r_resp_err    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_grant_found) begin
            r_block  <= w_grant_data;
            r_id     <= w_grant_idx;
            r_rr_ptr <= w_grant_idx;
            r_cnt    <= '0;
          end
        end
        StRun: begin
          r_cnt <= r_cnt + CntW'(1);
          if (i_aes_round_done) begin
            r_resp_data <= i_aes_xout;
            r_resp_err  <= 1'b0;
          end else if (w_timeout_hit) begin
            r_resp_data   <= '0;
            r_resp_err    <= 1'b1;
            r_timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs. Grants are suppressed while reset is held even though the
  // state already reads IDLE.
  always_comb begin
    o_req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      o_req_ready[i] = i_rstn && (r_state == StIdle) && w_grant_found &&
                       (w_grant_idx == IDW'(i));
    end
    o_start_round = (r_state == StRun);
    o_aes_xin     = (r_state == StRun) ? r_block : '0;
    o_resp_valid  = (r_state == StResp);
    o_busy        = (r_state != StIdle);
    o_resp_id     = r_id;
    o_resp_data   = r_resp_data;
    o_resp_err    = r_resp_err;
    o_timeout_err = r_timeout_err;
  end

endmodule

// File: tb/tb_aes_round_arbiter.sv
module tb_aes_round_arbiter;
  localparam int NREQ = 4;
  localparam int IDW = 2;
  localparam int TIMEOUT = 32;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*128-1:0] req_data = '0;
  logic [NREQ-1:0]     req_ready;
  logic                resp_valid;
  logic                resp_ready = 1'b1;
  logic [IDW-1:0]      resp_id;
  logic [127:0]        resp_data;
  logic                resp_err;
  logic                start_round;
  logic [127:0]        aes_xin;
  logic                aes_done;
  logic [127:0]        aes_xout;
  logic                busy;
  logic                timeout_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int eng_cnt = 0;
  int eng_lat = 10;

  int             q_id[$];
  logic [127:0]   q_data[$];
  logic           q_err[$];
  int             m_id;
  logic [127:0]   m_data;
  logic           m_err;

  aes_round_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk            (clk),
    .i_rstn           (rstn),
    .i_req_valid      (req_valid),
    .i_req_data       (req_data),
    .o_req_ready      (req_ready),
    .o_resp_valid     (resp_valid),
    .i_resp_ready     (resp_ready),
    .o_resp_id        (resp_id),
    .o_resp_data      (resp_data),
    .o_resp_err       (resp_err),
    .o_start_round    (start_round),
    .o_aes_xin        (aes_xin),
    .i_aes_round_done (aes_done),
    .i_aes_xout       (aes_xout),
    .o_busy           (busy),
    .o_timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: done once start has been high for eng_lat edges; output = ~input.
  always @(posedge clk) begin
    if (!start_round) eng_cnt <= 0;
    else              eng_cnt <= eng_cnt + 1;
  end
  assign aes_done = start_round && (eng_cnt >= eng_lat);
  assign aes_xout = aes_done ? ~aes_xin : '0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push(input int id, input logic [127:0] d, input logic e);
    q_id.push_back(id);
    q_data.push_back(d);
    q_err.push_back(e);
  endtask

  // Scoreboard monitor: compares every accepted response.
  always @(negedge clk) begin
    if (rstn && resp_valid && resp_ready) begin
      if (q_id.size() == 0) begin
        total++;
        bad++;
        $display("FAIL resp_unexpected: got id %0d data %h, required no response", resp_id,
                 resp_data);
      end else begin
        m_id = q_id.pop_front();
        m_data = q_data.pop_front();
        m_err = q_err.pop_front();
        check("resp_id", 128'(resp_id), 128'(m_id));
        check("resp_data", resp_data, m_data);
        check("resp_err", 128'(resp_err), 128'(m_err));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for the first grant, checks it is requester i, returns after the handshake edge.
  task automatic wait_grant(input int i, input bit keep, output int c);
    int n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("grant_req%0d", i), 128'(req_ready), 128'(4'b0001 << i));
    c = cyc;
    step();
    if (!keep) req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || resp_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 128'(busy), 128'(0));
  endtask

  task automatic op(input int i, input logic [127:0] d);
    int c;
    step();
    req_data[128*i +: 128] = d;
    req_valid[i] = 1'b1;
    push(i, ~d, 1'b0);
    wait_grant(i, 1'b0, c);
    wait_idle();
  endtask

  task automatic count_start(output int n);
    n = 0;
    @(negedge clk);
    while (start_round && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  localparam logic [127:0] D0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] D1 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] D2 = 128'hdeadbeefcafef00d0badc0de12345678;
  localparam logic [127:0] D3 = 128'h55aa55aa0f0f0f0f123412349876fedc;

  initial begin
    int gc, rc, n, c, rel;
    int gcs[6];
    int ids[6];
    logic [IDW-1:0] id0;
    logic [127:0] data0;
    bit hold_ok, sr_ok, rdy_ok;
    ids = '{0, 1, 2, 3, 0, 1};

    // Reset state
    #1;
    check("rst_req_ready", 128'(req_ready), 128'(0));
    check("rst_resp_valid", 128'(resp_valid), 128'(0));
    check("rst_start", 128'(start_round), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_xin", aes_xin, 128'(0));
    check("rst_resp_data", resp_data, 128'(0));
    check("rst_resp_id", 128'(resp_id), 128'(0));
    check("rst_resp_err", 128'(resp_err), 128'(0));
    check("rst_timeout_err", 128'(timeout_err), 128'(0));
    step();
    step();
    rstn = 1'b1;

    // Single request with latency check
    step();
    req_data[127:0] = D0;
    req_valid = 4'b0001;
    push(0, 128'hffeeddccbbaa99887766554433221100, 1'b0);
    wait_grant(0, 1'b0, gc);
    @(negedge clk);
    check("ready_one_cycle", 128'(req_ready), 128'(0));
    check("xin_in_run", aes_xin, D0);
    n = 0;
    while (!resp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    rc = cyc;
    check("latency_12", 128'(rc - gc), 128'(12));
    wait_idle();

    // Round robin from reset with all requesters held
    step();
    rstn = 1'b0;
    req_data = {D3, D2, D1, D0};
    req_valid = 4'b1111;
    resp_ready = 1'b1;
    step();
    rstn = 1'b1;
    push(0, ~D0, 1'b0);
    push(1, ~D1, 1'b0);
    push(2, ~D2, 1'b0);
    push(3, ~D3, 1'b0);
    push(0, ~D0, 1'b0);
    push(1, ~D1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      wait_grant(ids[k], 1'b1, gcs[k]);
      if (k > 0) check($sformatf("rr_spacing%0d", k), 128'(gcs[k] - gcs[k-1]), 128'(13));
    end
    req_valid = '0;
    wait_idle();

    // Backpressure: requester 2 wins, requester 3 must wait out the stall
    step();
    resp_ready = 1'b0;
    req_data[128*2 +: 128] = D2;
    req_data[128*3 +: 128] = D3;
    req_valid = 4'b1100;
    push(2, ~D2, 1'b0);
    push(3, ~D3, 1'b0);
    wait_grant(2, 1'b0, c);
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    id0 = resp_id;
    data0 = resp_data;
    hold_ok = 1'b1;
    sr_ok = 1'b1;
    rdy_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(resp_valid && resp_id == id0 && resp_data == data0)) hold_ok = 1'b0;
      if (start_round) sr_ok = 1'b0;
      if (req_ready != '0) rdy_ok = 1'b0;
    end
    check("bp_hold", 128'(hold_ok), 128'(1));
    check("bp_start_low", 128'(sr_ok), 128'(1));
    check("bp_no_grant", 128'(rdy_ok), 128'(1));
    check("bp_data", data0, ~D2);
    step();
    resp_ready = 1'b1;
    rel = cyc;
    wait_grant(3, 1'b0, c);
    check("bp_regrant", 128'(c - rel), 128'(1));
    wait_idle();

    // Timeout: engine never completes
    step();
    eng_lat = 1000;
    req_data[128*1 +: 128] = D1;
    req_valid = 4'b0010;
    push(1, 128'(0), 1'b1);
    wait_grant(1, 1'b0, c);
    count_start(n);
    check("timeout_start_len", 128'(n), 128'(32));
    wait_idle();
    check("timeout_err_set", 128'(timeout_err), 128'(1));
    eng_lat = 10;
    op(0, D0);
    op(2, D2);
    op(3, D3);
    check("timeout_err_sticky", 128'(timeout_err), 128'(1));

    // Reset in the middle of RUN
    step();
    req_data[128*3 +: 128] = D3;
    req_valid = 4'b1000;
    wait_grant(3, 1'b0, c);
    repeat (5) step();
    #1;
    rstn = 1'b0;
    #1;
    check("mid_rst_start", 128'(start_round), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_xin", aes_xin, 128'(0));
    check("mid_rst_resp_valid", 128'(resp_valid), 128'(0));
    check("mid_rst_timeout_err", 128'(timeout_err), 128'(0));
    req_data[127:0] = D0;
    req_data[128*2 +: 128] = D2;
    req_valid = 4'b0101;
    step();
    check("mid_rst_no_ready", 128'(req_ready), 128'(0));
    step();
    rstn = 1'b1;
    push(0, ~D0, 1'b0);
    push(2, ~D2, 1'b0);
    wait_grant(0, 1'b0, c);
    wait_grant(2, 1'b0, c);
    wait_idle();

    // Done coincides with the final timeout cycle: done wins
    step();
    eng_lat = TIMEOUT - 1;
    req_data[128*1 +: 128] = D1;
    req_valid = 4'b0010;
    push(1, ~D1, 1'b0);
    wait_grant(1, 1'b0, c);
    count_start(n);
    check("coinc_start_len", 128'(n), 128'(32));
    wait_idle();
    check("coinc_timeout_err", 128'(timeout_err), 128'(0));
    eng_lat = 10;

    repeat (3) step();
    check("sb_empty", 128'(q_id.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_round_arbiter.md
Name: aes_round_arbiter

Overview:
- Shares one iterative AES round engine (10 key steps, start/done handshake, keys wired directly to the engine) among NREQ requesters.
- Each requester offers a 128-bit block over a valid/ready handshake. The arbiter grants round-robin, sequences the engine's start_round/done protocol, and returns the result tagged with the requester id.
- It sits between the scratchpad/hash front-end lanes and the single aes_round instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester id; must be >= clog2(NREQ).
- TIMEOUT, 32, maximum cycles in RUN waiting for engine done before aborting (>= 12).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester block valid.
- req_data  in  NREQ*128  requester i's block in bits [128*i+127:128*i]; held stable while req_valid is high.
- req_ready  out  NREQ  one-hot grant; handshake completes when req_valid[i] & req_ready[i].
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  IDW  requester index of the result.
- resp_data  out  128  engine output block (0 on timeout).
- resp_err  out  1  result aborted by timeout.
- start_round  out  1  engine start; held high for the whole operation.
- aes_xin  out  128  engine input block.
- aes_round_done  in  1  engine done flag.
- aes_xout  in  128  engine output, valid while done is high.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky, set on any timeout.

Behaviour:
- Reset (async, rstn=0), all regardless of state:
  - state=IDLE; rr_ptr=NREQ-1.
  - start_round, resp_valid, resp_err and timeout_err = 0.
  - resp_data, resp_id, aes_xin and the latched block = 0.
  - req_ready = 0.
  - Reset mid-operation aborts silently with no response. start_round dropping makes the engine clear its own state.
- States: IDLE, RUN, RESP.
- IDLE:
  - Arbitration is combinational. Search indices rr_ptr+1, rr_ptr+2, ... modulo NREQ; the first i with req_valid[i] wins.
  - req_ready[i]=1 for the winner only, and only in IDLE. All other req_ready bits are 0.
  - On a grant: latch req_data slice and id, set rr_ptr=i, clear the timeout counter, next state RUN.
  - No request: stay in IDLE.
- RUN:
  - start_round=1; aes_xin=latched block (0 in every other state).
  - Counter increments each cycle.
  - If aes_round_done=1: capture aes_xout into resp_data, resp_err=0, next state RESP.
  - Else if counter==TIMEOUT-1: resp_data=0, resp_err=1, timeout_err=1, next state RESP.
  - If done and timeout coincide, done wins.
- RESP:
  - start_round=0, so the engine clears its counter and done flag on the next edge.
  - resp_valid=1; resp_id, resp_data and resp_err are held stable until resp_ready.
  - On resp_valid & resp_ready: resp_valid deasserts next edge, next state IDLE.
  - RESP always lasts at least 1 cycle, so start_round is low for at least 1 cycle between operations.
- Latency:
  - RUN is entered the cycle after the grant.
  - resp_valid rises the cycle after aes_round_done is first seen high in RUN.
  - With a 10-cycle engine (done high 10 edges after start rises), resp_valid is first high 12 cycles after the grant cycle.
- Throughput: back-to-back issue is possible. The grant can occur in the IDLE cycle immediately after the RESP handshake, giving 13 cycles per block with resp_ready held high.
- Fairness: a continuously requesting requester waits at most NREQ-1 other operations.
- Requests arriving while busy wait; there is no queueing inside the block.
- req_valid dropping without a grant is legal and ignored.
- aes_round_done high outside RUN is ignored.
- timeout_err is cleared only by reset.

Test Plan:
- Single request: req_valid=0001, data=128'h00112233445566778899aabbccddeeff; engine model with latency 10 echoing xin^{128{1}} -> req_ready[0] for 1 cycle; resp_valid 12 cycles later with resp_id=0, resp_data=~data, resp_err=0.
- Round robin: all four req_valid held high from reset; resp_ready=1 -> grant order 0,1,2,3,0,1; each resp_id matches; grants 13 cycles apart.
- Backpressure: resp_ready=0 for 20 cycles after resp_valid -> resp_valid, resp_id and resp_data held constant; start_round=0; no new req_ready; grant one cycle after resp_ready=1.
- Timeout: engine never asserts done, TIMEOUT=32 -> start_round high exactly 32 cycles; resp_valid with resp_err=1, resp_data=0; timeout_err=1 and still 1 after 3 further normal operations.
- Reset mid-RUN: pull rstn low 5 cycles into RUN -> outputs zero asynchronously with no resp_valid; after release, requester 0 pending with requester 2 also pending gets the first grant (rr_ptr=NREQ-1).
- Coincidence: done asserted in the same cycle the counter hits TIMEOUT-1 -> resp_err=0, resp_data=aes_xout, timeout_err stays 0.
